pmem_responder: RTL and testbench

- Physical-memory-side responder for the cache's cacheline port: accepts one 256-bit line read or write at a time from the cache/adaptor and completes it with a single-cycle pmem_resp after a programmable latency.
- Backed by an internal line array; serves as the synthesizable memory model behind the cache in integration benches and FPGA builds.
- Tracks completed reads and writes in saturating counters for performance checks.

---
 rtl/pmem_responder.sv | 179 +++++++++++++++++
 tb/tb_pmem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// pmem_responder: cacheline-port memory responder.
// Accepts one line read or write at a time, completes it with a one-cycle
// pmem_resp exactly LATENCY cycles after acceptance, and keeps saturating
// counts of completed reads and writes.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for pmem_read/pmem_write; accepts on the clock edge
// BUSY  | request captured, latency down-counter running
// RESP  | pmem_resp high for this single cycle; always back to IDLE
module pmem_responder #(
    parameter int LINE_W  = 256,
    parameter int IDX_W   = 4,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int         OFF_W   = $clog2(LINE_W / 8);
    localparam int         DEPTH   = 1 << IDX_W;
    localparam int         IDX_TOP = OFF_W + IDX_W;
    localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("pmem_responder: LATENCY must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                op_rd_q;
    logic [IDX_W-1:0]    idx_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [LINE_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                enter_resp;
    logic [IDX_W-1:0]    addr_idx;
    logic                req_rd;
    logic [IDX_W-1:0]    req_idx;
    logic [LINE_W-1:0]   req_wdata;
    logic                mem_we;
    logic                unused_addr;

    // Only the index field selects a line; offset and high bits alias.
    assign addr_idx    = pmem_address[OFF_W +: IDX_W];
    assign unused_addr = ^{pmem_address[31:IDX_TOP], pmem_address[OFF_W-1:0]};

    // Next-state logic: acceptance in IDLE, latency countdown in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY > 1) ? ST_BUSY : ST_RESP;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request at acceptance; later input changes are ignored.
    // A simultaneous read and write is recorded as a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_rd_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_rd_q <= pmem_read;
            idx_q   <= addr_idx;
            wdata_q <= pmem_wdata;
        end
    end

    // With LATENCY=1 the edge entering RESP is also the acceptance edge, so
    // the captured registers are not loaded yet; use the live inputs then.
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign req_rd     = (state_q == ST_IDLE) ? pmem_read    : op_rd_q;
    assign req_idx    = (state_q == ST_IDLE) ? addr_idx     : idx_q;
    assign req_wdata  = (state_q == ST_IDLE) ? pmem_wdata   : wdata_q;

    // A write in flight while rst is high must never reach the array.
    assign mem_we = enter_resp && !req_rd && !rst;

    // Read data and completion counters.
    always_comb begin
        rdata_d    = rdata_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (enter_resp && req_rd) begin
            rdata_d = mem_q[req_idx];
        end
        if (state_q == ST_RESP) begin
            if (op_rd_q) begin
                if (rd_count_q != CNT_MAX) begin
                    rd_count_d = rd_count_q + 16'd1;
                end
            end else begin
                if (wr_count_q != CNT_MAX) begin
                    wr_count_d = wr_count_q + 16'd1;
                end
            end
        end
    end

    // Read data and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rdata_q    <= rdata_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Line array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[req_idx] <= req_wdata;
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: one instance at LATENCY=4, one at
// LATENCY=1 for back-to-back timing.
module tb_pmem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         pmem_read = 1'b0, pmem_write = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp, busy;
    logic [15:0]  rd_count, wr_count;

    logic         rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0]  addr1 = '0;
    logic [255:0] wdata1 = '0;
    logic [255:0] rdata1;
    logic         resp1, busy1;
    logic [15:0]  rd_count1, wr_count1;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [255:0] D_A5 = {32{8'hA5}};
    localparam logic [255:0] D_X  = {8{32'h1234_5678}};
    localparam logic [255:0] D_Y  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] D_Z  = {8{32'h0F0F_F0F0}};
    localparam logic [255:0] D_Y5 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] D_W  = {16{16'hC3C3}};

    pmem_responder #(.LINE_W(256), .IDX_W(4), .LATENCY(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    pmem_responder #(.LINE_W(256), .IDX_W(4), .LATENCY(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (rd1),
        .pmem_write   (wr1),
        .pmem_address (addr1),
        .pmem_wdata   (wdata1),
        .pmem_rdata   (rdata1),
        .pmem_resp    (resp1),
        .busy         (busy1),
        .rd_count     (rd_count1),
        .wr_count     (wr_count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=4 instance starting at a negedge.
    // lat = number of negedges after acceptance setup until pmem_resp seen.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, input bit scramble,
                         output int lat, output logic [255:0] rdat);
        lat          = 0;
        rdat         = '0;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (scramble && c == 1) begin
                pmem_address = ~addr;
                pmem_wdata   = ~wd;
            end
            if (pmem_resp) begin
                lat  = c;
                rdat = pmem_rdata;
                break;
            end
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", {255'd0, pmem_resp}, 256'd0);
    endtask

    initial begin
        int           lat;
        logic [255:0] rd_data;
        logic         seen;
        logic [5:0]   pat;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_resp", {255'd0, pmem_resp}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_rdata", pmem_rdata, 256'd0);
        chk("rst_counts", {224'd0, rd_count, wr_count}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write then read, LATENCY=4
        do_op(1'b0, 1'b1, 32'h0000_0040, D_A5, 1'b0, lat, rd_data);
        chk("wr_latency", 256'(lat), 256'd4);
        do_op(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, lat, rd_data);
        chk("rd_latency", 256'(lat), 256'd4);
        chk("rd_data_a5", rd_data, D_A5);
        chk("rdata_held", pmem_rdata, D_A5);
        chk("cnt_after_wr_rd", {224'd0, rd_count, wr_count}, {224'd0, 16'd1, 16'd1});

        // Aliasing of high bits and ignored offset
        do_op(1'b0, 1'b1, 32'h0000_0200, D_X, 1'b0, lat, rd_data);
        do_op(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0, lat, rd_data);
        chk("alias_hi", rd_data, D_X);
        do_op(1'b1, 1'b0, 32'h0000_021F, '0, 1'b0, lat, rd_data);
        chk("alias_offset", rd_data, D_X);
        chk("cnt_alias", {224'd0, rd_count, wr_count}, {224'd0, 16'd3, 16'd2});

        // Simultaneous read+write to index 3: read wins, no commit
        do_op(1'b0, 1'b1, 32'h0000_0060, D_Y, 1'b0, lat, rd_data);
        do_op(1'b1, 1'b1, 32'h0000_0060, D_Z, 1'b0, lat, rd_data);
        chk("rdwr_data", rd_data, D_Y);
        chk("cnt_rdwr", {224'd0, rd_count, wr_count}, {224'd0, 16'd4, 16'd3});
        do_op(1'b1, 1'b0, 32'h0000_0060, '0, 1'b0, lat, rd_data);
        chk("rdwr_no_commit", rd_data, D_Y);

        // Reset in the middle of a write to index 5
        do_op(1'b0, 1'b1, 32'h0000_00A0, D_Y5, 1'b0, lat, rd_data);
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_00A0;
        pmem_wdata   = D_Z;
        @(negedge clk);
        @(negedge clk);
        chk("busy_mid_write", {255'd0, busy}, {255'd0, 1'b1});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_resp", {255'd0, pmem_resp}, 256'd0);
        chk("async_rst_busy", {255'd0, busy}, 256'd0);
        chk("async_rst_rdata", pmem_rdata, 256'd0);
        chk("async_rst_counts", {224'd0, rd_count, wr_count}, 256'd0);
        pmem_write = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen = seen | pmem_resp;
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen = seen | pmem_resp;
        end
        chk("aborted_no_resp", {255'd0, seen}, 256'd0);
        do_op(1'b1, 1'b0, 32'h0000_00A0, '0, 1'b0, lat, rd_data);
        chk("aborted_no_commit", rd_data, D_Y5);
        chk("cnt_after_abort", {224'd0, rd_count, wr_count}, {224'd0, 16'd1, 16'd0});

        // Inputs changed after acceptance have no effect
        do_op(1'b0, 1'b1, 32'h0000_00C0, D_W, 1'b1, lat, rd_data);
        chk("scramble_latency", 256'(lat), 256'd4);
        do_op(1'b1, 1'b0, 32'h0000_00C0, '0, 1'b0, lat, rd_data);
        chk("no_resample", rd_data, D_W);

        // Counter saturation (preload near the top)
        force dut.rd_count_q = 16'hFFFE;
        force dut.wr_count_q = 16'hFFFE;
        #1;
        release dut.rd_count_q;
        release dut.wr_count_q;
        @(negedge clk);
        do_op(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, lat, rd_data);
        chk("rd_cnt_reach_max", {240'd0, rd_count}, {240'd0, 16'hFFFF});
        do_op(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, lat, rd_data);
        chk("rd_cnt_saturate", {240'd0, rd_count}, {240'd0, 16'hFFFF});
        do_op(1'b0, 1'b1, 32'h0000_0080, D_X, 1'b0, lat, rd_data);
        chk("wr_cnt_reach_max", {240'd0, wr_count}, {240'd0, 16'hFFFF});
        do_op(1'b0, 1'b1, 32'h0000_0080, D_X, 1'b0, lat, rd_data);
        chk("wr_cnt_saturate", {240'd0, wr_count}, {240'd0, 16'hFFFF});

        // LATENCY=1 instance: one-cycle response and back-to-back spacing
        wr1    = 1'b1;
        addr1  = 32'h0000_0040;
        wdata1 = D_Z;
        @(negedge clk);
        chk("l1_wr_resp", {255'd0, resp1}, {255'd0, 1'b1});
        wr1 = 1'b0;
        @(negedge clk);
        chk("l1_wr_pulse_end", {255'd0, resp1}, 256'd0);
        chk("l1_wr_count", {240'd0, wr_count1}, {240'd0, 16'd1});
        rd1 = 1'b1;
        pat = '0;
        rd_data = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            pat[c-1] = resp1;
            if (c == 1) rd_data = rdata1;
        end
        rd1 = 1'b0;
        chk("l1_b2b_pattern", {250'd0, pat}, {250'd0, 6'b010101});
        chk("l1_rd_data", rd_data, D_Z);
        chk("l1_rd_count", {240'd0, rd_count1}, {240'd0, 16'd3});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
